// File: rtl/syncro_filt.sv
// syncro_filt: multi-channel probe synchroniser with optional per-channel glitch filter
// and registered rise/fall strobes. Define SYNCRO_FILT_EN to build in the glitch filter.

module syncro_filt_lane #(
   parameter int   STAGES   = 2,
   parameter int   FILT_LEN = 4,
   parameter logic INIT     = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   if (STAGES < 2) begin : g_bad_stages
      $error("syncro_filt: STAGES must be >= 2");
   end
   if (FILT_LEN < 1) begin : g_bad_filt
      $error("syncro_filt: FILT_LEN must be >= 1");
   end

   // stg[STAGES-1] is the only stage anything downstream looks at
   logic [STAGES-1:0] stg;

   always_ff @(posedge clk) begin
      if (!rst_n) stg <= {STAGES{INIT}};
      else        stg <= {stg[STAGES-2:0], din};
   end

`ifdef SYNCRO_FILT_EN
   localparam int CW = $clog2(FILT_LEN + 1);
   logic [CW-1:0] cnt;

   // Accept a new level only after FILT_LEN consecutive cycles of disagreement
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         sync <= INIT;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (stg[STAGES-1] == sync) begin
            cnt <= '0;
         end else if (cnt == CW'(FILT_LEN - 1)) begin
            cnt  <= '0;
            sync <= stg[STAGES-1];
            rise <= stg[STAGES-1];
            fall <= ~stg[STAGES-1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
`else
   assign sync = stg[STAGES-1];

   // Strobe registered on the same edge the last stage takes its new value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= stg[STAGES-2] & ~stg[STAGES-1];
         fall <= ~stg[STAGES-2] & stg[STAGES-1];
      end
   end
`endif

   a_no_dual_strobe: assert property (@(posedge clk) !(rise && fall));

endmodule

module syncro_filt #(
   parameter int               WIDTH    = 1,
   parameter int               STAGES   = 2,
   parameter int               FILT_LEN = 4,
   parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      syncro_filt_lane #(
         .STAGES   (STAGES),
         .FILT_LEN (FILT_LEN),
         .INIT     (INIT_VAL[i])
      ) u_lane (
         .clk   (clk_i),
         .rst_n (rst_in),
         .din   (async_i[i]),
         .sync  (sync_o[i]),
         .rise  (rise_o[i]),
         .fall  (fall_o[i])
      );
   end

endmodule

// File: tb/tb_syncro_filt.sv
// Scoreboard bench for syncro_filt: stimulus pushes expected strobe events,
// a negedge monitor pops and compares them whenever a strobe appears.

module tb_syncro_filt;

   localparam int WIDTH    = 4;
   localparam int STAGES   = 3;
   localparam int FILT_LEN = 4;
`ifdef SYNCRO_FILT_EN
   localparam int L = STAGES + FILT_LEN;
`else
   localparam int L = STAGES;
`endif

   logic             clk = 1'b0;
   logic             rst_in;
   logic [WIDTH-1:0] async_i;
   logic [WIDTH-1:0] sync_o, rise_o, fall_o;

   syncro_filt #(
      .WIDTH    (WIDTH),
      .STAGES   (STAGES),
      .FILT_LEN (FILT_LEN),
      .INIT_VAL (4'b1111)
   ) dut (
      .clk_i   (clk),
      .rst_in  (rst_in),
      .async_i (async_i),
      .sync_o  (sync_o),
      .rise_o  (rise_o),
      .fall_o  (fall_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] sync;
      logic [3:0] rise;
      logic [3:0] fall;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic push(input int c, input logic [3:0] s, input logic [3:0] r, input logic [3:0] f);
      exp_t e;
      e.cyc = c; e.sync = s; e.rise = r; e.fall = f;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every strobe must match the next expected event exactly
   always @(negedge clk) begin
      exp_t e;
      if (cyc > 0 && (rise_o !== 4'b0 || fall_o !== 4'b0)) begin
         if (q.size() == 0) begin
            chk("unexpected_strobe", {24'b0, rise_o, fall_o}, 32'b0);
         end else begin
            e = q.pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_sync", sync_o, e.sync);
            chk("strobe_rise", rise_o, e.rise);
            chk("strobe_fall", fall_o, e.fall);
         end
      end
   end

   initial begin
      int t;
      rst_in  = 1'b0;
      async_i = 4'b0000;

      // Reset with inputs low: outputs pinned at INIT_VAL, no strobes
      repeat (5) begin
         @(negedge clk);
         chk("rst_sync", sync_o, 4'b1111);
         chk("rst_rise", rise_o, 4'b0);
         chk("rst_fall", fall_o, 4'b0);
      end

      // Release; ch3 settles low, others stay high
      rst_in  = 1'b1;
      async_i = 4'b0111;
      push(cyc + L, 4'b0111, 4'b0000, 4'b1000);
      step(12);
      chk("settle_sync", sync_o, 4'b0111);

      // ch0 1->0: latency check one cycle before the update
      t = cyc;
      async_i = 4'b0110;
      push(t + L, 4'b0110, 4'b0000, 4'b0001);
      step(L - 1);
      chk("ch0_early", sync_o, 4'b0111);
      step(12);
      chk("ch0_sync", sync_o, 4'b0110);

      // ch1 3-cycle pulse: rejected by the filter, passed when unfiltered
      t = cyc;
      async_i = 4'b0100;
`ifndef SYNCRO_FILT_EN
      push(t + L, 4'b0100, 4'b0000, 4'b0010);
`endif
      step(3);
      async_i = 4'b0110;
`ifndef SYNCRO_FILT_EN
      push(t + 3 + L, 4'b0110, 4'b0010, 4'b0000);
`endif
      step(14);
      chk("pulse3_sync", sync_o, 4'b0110);

      // ch1 4-cycle pulse: accepted, low for 4 cycles
      t = cyc;
      async_i = 4'b0100;
      push(t + L, 4'b0100, 4'b0000, 4'b0010);
      step(4);
      async_i = 4'b0110;
      push(t + 4 + L, 4'b0110, 4'b0010, 4'b0000);
      step(14);
      chk("pulse4_sync", sync_o, 4'b0110);

      // ch2 falls and ch3 rises together
      t = cyc;
      async_i = 4'b1010;
      push(t + L, 4'b1010, 4'b1000, 4'b0100);
      step(12);
      chk("opp_sync", sync_o, 4'b1010);

      // All high again before the reset-abort case
      t = cyc;
      async_i = 4'b1111;
      push(t + L, 4'b1111, 4'b0101, 4'b0000);
      step(12);
      chk("allhigh_sync", sync_o, 4'b1111);

      // ch0 change pending (cnt=2 in filtered build) when reset hits
      t = cyc;
      async_i = 4'b1110;
`ifndef SYNCRO_FILT_EN
      push(t + L, 4'b1110, 4'b0000, 4'b0001);
`endif
      step(5);
      rst_in = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("abort_rst_sync", sync_o, 4'b1111);
         chk("abort_rst_rise", rise_o, 4'b0);
         chk("abort_rst_fall", fall_o, 4'b0);
      end
      rst_in = 1'b1;
      t = cyc;
      push(t + L, 4'b1110, 4'b0000, 4'b0001);
      step(L - 1);
      chk("abort_early", sync_o, 4'b1111);
      step(12);
      chk("abort_sync", sync_o, 4'b1110);

      chk("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
